// File: rtl/cnn_line_fifo_if.sv
// Bundle of write, line-read and chip-read signals for cnn_line_fifo.
// The master side drives pixels and read requests; the slave side is the line FIFO.
interface cnn_line_fifo_if #(
    parameter int DW       = 16,
    parameter int LINE_LEN = 10,
    parameter int COL_W    = 4,
    parameter int LINE_W   = 2,
    parameter int CNT_W    = 2
);

    logic [DW-1:0]          wr_data;
    logic                   wr_valid;
    logic                   wr_ready;
    logic                   line_done;
    logic [CNT_W-1:0]       lines_avail;
    logic                   line_rd_en;
    logic [LINE_LEN*DW-1:0] line_data_out;
    logic                   line_data_valid;
    logic                   line_release;
    logic [LINE_W-1:0]      chip_line;
    logic [COL_W-1:0]       chip_add;
    logic                   chiprd_en;
    logic [DW-1:0]          chip_data_out;
    logic                   chip_data_valid;
    logic                   err;

    modport master (
        output wr_data, wr_valid, line_rd_en, line_release,
               chip_line, chip_add, chiprd_en,
        input  wr_ready, line_done, lines_avail, line_data_out,
               line_data_valid, chip_data_out, chip_data_valid, err
    );

    modport slave (
        input  wr_data, wr_valid, line_rd_en, line_release,
               chip_line, chip_add, chiprd_en,
        output wr_ready, line_done, lines_avail, line_data_out,
               line_data_valid, chip_data_out, chip_data_valid, err
    );

endinterface

// File: rtl/cnn_line_fifo.sv
// Ring of NUM_LINES feature-map lines: streamed pixel writes, whole-line and word reads.
// Define LINE_FIFO_ERR_EN to build the sticky protocol-error detector driving err.
module cnn_line_fifo #(
    parameter int DW        = 16,
    parameter int LINE_LEN  = 10,
    parameter int NUM_LINES = 3,
    parameter int COL_W     = 4,
    parameter int LINE_W    = 2,
    parameter int CNT_W     = 2
) (
    input  logic           clk,
    input  logic           reset,
    cnn_line_fifo_if.slave bus
);

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LINE_LEN - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_LINES);

    logic [DW-1:0]          mem_q [NUM_LINES][LINE_LEN];

    logic [COL_W-1:0]       wrCol_q, wrCol_d;
    logic [LINE_W-1:0]      wrLine_q, wrLine_d;
    logic [LINE_W-1:0]      rdLine_q, rdLine_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   lineDone_q;
    logic [LINE_LEN*DW-1:0] lineData_q, lineData_d;
    logic                   lineValid_q, lineValid_d;
    logic [DW-1:0]          chipData_q, chipData_d;
    logic                   chipValid_q, chipValid_d;

    logic                   wrReady;
    logic                   wrAccept;
    logic                   lineEnd;
    logic                   notEmpty;
    logic                   doRelease;
    logic                   lineRead;
    logic                   chipOk;
    logic [LINE_W-1:0]      chipIdx;
    int                     chipSum;

    assign notEmpty  = (count_q != '0);
    assign wrReady   = (count_q < FULL_CNT);
    assign wrAccept  = bus.wr_valid && wrReady;
    assign lineEnd   = wrAccept && (wrCol_q == LAST_COL);
    assign doRelease = bus.line_release && notEmpty;
    assign lineRead  = bus.line_rd_en && notEmpty;
    assign chipOk    = bus.chiprd_en
                       && (32'(bus.chip_line) < 32'(count_q))
                       && (32'(bus.chip_add) < 32'(LINE_LEN));

    always_comb begin
        wrCol_d  = wrCol_q;
        wrLine_d = wrLine_q;
        rdLine_d = rdLine_q;
        count_d  = count_q;

        if (wrAccept) begin
            if (lineEnd) begin
                wrCol_d  = '0;
                wrLine_d = (wrLine_q == LAST_LINE) ? '0 : wrLine_q + 1'b1;
            end else begin
                wrCol_d = wrCol_q + 1'b1;
            end
        end

        if (doRelease) begin
            rdLine_d = (rdLine_q == LAST_LINE) ? '0 : rdLine_q + 1'b1;
        end

        // Completion and release together leave the count untouched
        case ({lineEnd, doRelease})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Ring slot for the chip read; both terms are below NUM_LINES whenever chipOk holds
    always_comb begin
        chipSum = int'(rdLine_q) + int'(bus.chip_line);
        if (chipSum >= NUM_LINES) begin
            chipSum = chipSum - NUM_LINES;
        end
        chipIdx = LINE_W'(chipSum);
    end

    always_comb begin
        lineData_d  = '0;
        lineValid_d = 1'b0;
        chipData_d  = '0;
        chipValid_d = 1'b0;

        if (lineRead) begin
            lineValid_d = 1'b1;
            for (int i = 0; i < LINE_LEN; i++) begin
                lineData_d[(LINE_LEN-1-i)*DW +: DW] = mem_q[rdLine_q][i];
            end
        end

        if (chipOk) begin
            chipValid_d = 1'b1;
            chipData_d  = mem_q[chipIdx][bus.chip_add];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < NUM_LINES; l++) begin
                for (int c = 0; c < LINE_LEN; c++) begin
                    mem_q[l][c] <= '0;
                end
            end
            wrCol_q     <= '0;
            wrLine_q    <= '0;
            rdLine_q    <= '0;
            count_q     <= '0;
            lineDone_q  <= 1'b0;
            lineData_q  <= '0;
            lineValid_q <= 1'b0;
            chipData_q  <= '0;
            chipValid_q <= 1'b0;
        end else begin
            if (wrAccept) begin
                mem_q[wrLine_q][wrCol_q] <= bus.wr_data;
            end
            wrCol_q     <= wrCol_d;
            wrLine_q    <= wrLine_d;
            rdLine_q    <= rdLine_d;
            count_q     <= count_d;
            lineDone_q  <= lineEnd;
            lineData_q  <= lineData_d;
            lineValid_q <= lineValid_d;
            chipData_q  <= chipData_d;
            chipValid_q <= chipValid_d;
        end
    end

`ifdef LINE_FIFO_ERR_EN
    logic err_q;
    logic errHit;

    assign errHit = (bus.wr_valid && !wrReady)
                    || (bus.line_release && !notEmpty)
                    || (bus.line_rd_en && !notEmpty)
                    || (bus.chiprd_en && !chipOk);

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (errHit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.wr_ready        = wrReady;
    assign bus.line_done       = lineDone_q;
    assign bus.lines_avail     = count_q;
    assign bus.line_data_out   = lineData_q;
    assign bus.line_data_valid = lineValid_q;
    assign bus.chip_data_out   = chipData_q;
    assign bus.chip_data_valid = chipValid_q;

endmodule

// File: doc/cnn_line_fifo.md
Name: cnn_line_fifo

Overview:
- Parametrised successor to the single-line feature-map memory.
- Holds NUM_LINES lines of LINE_LEN words each, organised as a ring (FIFO of lines).
- Pixels stream in with a valid/ready handshake and an auto-incrementing address. The oldest complete line is presented as one flattened word for the conv engine.
- A random-access chip read port returns single words from any complete line. Sits between the input/pooling stage and the next convolution layer.

Parameters:
DW, 16, word width in bits
LINE_LEN, 10, words per line
NUM_LINES, 3, line slots in the ring
COL_W, 4, column index width; must satisfy 2^COL_W >= LINE_LEN
LINE_W, 2, line index width; must satisfy 2^LINE_W >= NUM_LINES
CNT_W, 2, width of lines_avail; must satisfy 2^CNT_W > NUM_LINES

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
wr_data  input  DW  pixel to write
wr_valid  input  1  wr_data valid this cycle
wr_ready  output  1  block accepts wr_data this cycle
line_done  output  1  one-cycle pulse: a line just completed
lines_avail  output  CNT_W  number of complete, unreleased lines
line_rd_en  input  1  request oldest complete line
line_data_out  output  LINE_LEN*DW  oldest line, word 0 in the MSBs
line_data_valid  output  1  line_data_out valid
line_release  input  1  pop oldest complete line
chip_line  input  LINE_W  line offset from oldest (0 = oldest)
chip_add  input  COL_W  column within line
chiprd_en  input  1  chip read request
chip_data_out  output  DW  chip read data
chip_data_valid  output  1  chip_data_out valid
err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (reset=0 at a rising edge):
  - All storage cleared to 0.
  - wr_line, wr_col, rd_line and the count are cleared to 0.
  - Outputs: line_done=0, line_data_out=0, line_data_valid=0, chip_data_out=0, chip_data_valid=0, err=0, lines_avail=0, wr_ready=1.
  - Reset mid-line discards the partial line.
- Write:
  - wr_ready = (count < NUM_LINES), combinational.
  - A word is accepted when wr_valid && wr_ready. It is stored at mem[wr_line][wr_col], then wr_col increments.
  - When wr_col == LINE_LEN-1 on acceptance: wr_col->0, wr_line advances (wraps NUM_LINES-1 -> 0), count+1, line_done=1 next cycle.
  - A partially written line is never visible on either read port.
- Release:
  - line_release with count>0: rd_line advances (with wrap), count-1.
  - Release with count==0 is ignored.
  - Line completion and release in the same cycle: count unchanged, both pointers advance.
  - A freed slot is writable the cycle after release. Old contents are overwritten, not cleared.
- Line read:
  - line_rd_en at edge N with count>0: at edge N+1, line_data_out = {mem[rd_line][0] .. mem[rd_line][LINE_LEN-1]} and line_data_valid=1.
  - line_rd_en with count==0: line_data_out=0, line_data_valid=0.
  - line_rd_en deasserted: line_data_out=0 and line_data_valid=0 at the next edge.
  - Read and release in the same cycle: the data returned is the pre-release line.
- Chip read:
  - 1-cycle registered latency.
  - If chiprd_en && chip_line < count && chip_add < LINE_LEN: chip_data_out = mem[(rd_line+chip_line) mod NUM_LINES][chip_add] and chip_data_valid=1.
  - Otherwise: chip_data_out=0 and chip_data_valid=0.
- No read/write exclusion: the write slot is never a complete line, so a simultaneous write and read never conflict.
- lines_avail = count, registered.

Optional Feature:
LINE_FIFO_ERR_EN
- Defined: err sets and holds until reset on any of:
  - wr_valid while wr_ready==0
  - line_release while count==0
  - line_rd_en while count==0
  - chiprd_en with chip_line >= count or chip_add >= LINE_LEN
- Undefined: err tied to 0 and no detection logic is built. All other behaviour is identical in both builds.

Test Plan:
- Reset, then stream 1..10 with wr_valid=1 -> line_done pulses once after word 10; lines_avail=1; line_rd_en gives line_data_out = {16'd1 .. 16'd10} with line_data_valid=1 one cycle later.
- Stream 30 words (1..30) with no release -> wr_ready=0 after word 30, lines_avail=3; a 31st word is not stored; with ERR_EN, err=1.
- With 3 lines full, pulse line_release -> lines_avail=2, wr_ready=1; write 31..40 -> slot 0 is overwritten; chip_line=2, chip_add=0 returns 31.
- chiprd_en with chip_line=0, chip_add=12 -> chip_data_out=0, chip_data_valid=0; chip_add=9 on line 0 holding 11..20 -> 20 one cycle later.
- Word 10 accepted in the same cycle as line_release with lines_avail=1 -> lines_avail stays 1; rd_line advances to the new line.
- Reset asserted after 5 words -> lines_avail=0; the next 10 words form line 0 starting at column 0; chip reads of the old data return 0.
